hack_alu_mul_seq: RTL and testbench

//  Multi-cycle sequencer that drives one shared combinational hack_alu to compute
//  16x16 -> low-16-bit products by shift-and-add; the ALU has no multiplier or shifter.

---
 rtl/hack_alu_mul_seq.sv | 148 ++++++++++++++
 tb/tb_hack_alu_mul_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu_mul_seq.sv
// Shift-and-add 16x16 -> low-WIDTH multiplier that sequences a shared combinational hack_alu.
// Optional macro EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module hack_alu_mul_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_zr,
  output logic             out_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  localparam int unsigned CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             last_c;

  // The ALU flags are not needed: result flags come from the accumulator.
  logic unused_flags;
  assign unused_flags = alu_zr ^ alu_ng;

  // Next-state and datapath updates; the ALU result is consumed in the same cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);
    last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (b_q[0]) acc_d = alu_out;
        state_d = DBL;
      end
      DBL: begin
        a_d    = alu_out;
        b_d    = b_q >> 1;
        cnt_d  = cnt_inc;
        last_c = (cnt_inc == CW'(ITER));
`ifdef EARLY_TERM_EN
        if (b_d == '0) last_c = 1'b1;
`endif
        state_d = last_c ? DONE : ADD;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers and registered outputs; ALU drive is computed from next state so it is valid in-state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_zr    <= 1'b1;
      out_ng    <= 1'b0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_zx    <= 1'b1;
      alu_nx    <= 1'b0;
      alu_zy    <= 1'b1;
      alu_ny    <= 1'b0;
      alu_f     <= 1'b1;
      alu_no    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (state_d == DONE) begin
        out_p  <= acc_d;
        out_zr <= (acc_d == '0);
        out_ng <= acc_d[WIDTH-1];
      end
      alu_nx <= 1'b0;
      alu_ny <= 1'b0;
      alu_f  <= 1'b1;
      alu_no <= 1'b0;
      case (state_d)
        ADD: begin
          alu_x  <= acc_d;
          alu_y  <= a_d;
          alu_zx <= 1'b0;
          alu_zy <= 1'b0;
        end
        DBL: begin
          alu_x  <= a_d;
          alu_y  <= a_d;
          alu_zx <= 1'b0;
          alu_zy <= 1'b0;
        end
        default: begin
          alu_x  <= '0;
          alu_y  <= '0;
          alu_zx <= 1'b1;
          alu_zy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_alu_mul_seq.sv
// Bench for hack_alu_mul_seq: hack ALU model, arithmetic product/latency/trace reference.
module tb_hack_alu_mul_seq;

  localparam int unsigned W    = 16;
  localparam int unsigned ITER = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic [W-1:0] out_p;
  logic         out_zr, out_ng;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic         alu_zr, alu_ng;
  logic [W-1:0] hx, hy, ho;

  int checks = 0;
  int errors = 0;

  hack_alu_mul_seq #(.WIDTH(W), .ITER(ITER)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_zr(out_zr), .out_ng(out_ng),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  always #5 clk = ~clk;

  // Combinational Hack ALU
  always_comb begin
    hx = alu_zx ? '0 : alu_x;
    if (alu_nx) hx = ~hx;
    hy = alu_zy ? '0 : alu_y;
    if (alu_ny) hy = ~hy;
    ho = alu_f ? (hx + hy) : (hx & hy);
    if (alu_no) ho = ~ho;
    alu_out = ho;
    alu_zr  = (ho == '0);
    alu_ng  = ho[W-1];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat(input logic [W-1:0] b);
    int n;
    n = ITER;
`ifdef EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < int'(W); i++) if (b[i]) n = i + 1;
    if (n > int'(ITER)) n = ITER;
`endif
    if (b === 'x) n = ITER;
    return 2 * n;
  endfunction

  function automatic logic [W-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    return W'(ua * ub);
  endfunction

  // Runs one multiply; checks latency, per-cycle ALU drive, result, hold and handshake.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit noise, output logic [W-1:0] p);
    int          n, lat, bad, k, elat;
    int unsigned ua, ub, ex, ey;
    bit          seen;
    logic [W-1:0] pe, held;
    ua = a;
    ub = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait got %b expected 1", in_ready);
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    lat = 0;
    bad = 0;
    while (!seen && lat < 200) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        k = lat / 2;
        ey = (ua << k) & 32'hFFFF;
        ex = ((lat % 2) == 0) ? ((ua * (ub & ((32'd1 << k) - 1))) & 32'hFFFF) : ey;
        if (alu_x !== W'(ex) || alu_y !== W'(ey)) bad++;
        if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b000010) bad++;
        if (in_ready !== 1'b0) bad++;
        if (noise) begin
          in_valid  = 1'($urandom);
          in_a      = W'($urandom);
          in_b      = W'($urandom);
          out_ready = 1'($urandom);
        end
        @(negedge clk);
        lat++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    pe = exp_prod(a, b);
    elat = exp_lat(b);
    checks++;
    if (!seen || lat != elat) begin
      errors++;
      $display("FAIL latency a=%h b=%h got %0d expected %0d", a, b, lat, elat);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL alu_trace a=%h b=%h got %0d bad cycles expected 0", a, b, bad);
    end
    checks++;
    if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b101010) begin
      errors++;
      $display("FAIL done_code got %b expected 101010", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    end
    checks++;
    if (out_p !== pe || out_zr !== (pe == '0) || out_ng !== pe[W-1]) begin
      errors++;
      $display("FAIL product a=%h b=%h got %h zr%b ng%b expected %h zr%b ng%b",
               a, b, out_p, out_zr, out_ng, pe, (pe == '0), pe[W-1]);
    end
    held = out_p;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (noise) in_valid = 1'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_p !== held || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL hold got %0d unstable cycles expected 0", bad);
      end
    end
    p = out_p;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake got rdy%b vld%b expected rdy1 vld0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0 || out_zr !== 1'b1 || out_ng !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy%b vld%b p%h zr%b ng%b expected rdy1 vld0 p0000 zr1 ng0",
               in_ready, out_valid, out_p, out_zr, out_ng);
    end
    checks++;
    if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b101010) begin
      errors++;
      $display("FAIL reset_code got %b expected 101010", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] p;
    run_mul(16'd17, 16'd3, 0, 1'b0, p);
    checks++;
    if (p !== 16'h0033) begin
      errors++;
      $display("FAIL basic_17x3 got %h expected 0033", p);
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] p;
    run_mul(16'hFFFF, 16'hFFFF, 0, 1'b0, p);
    checks++;
    if (p !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_ffff got %h expected 0001", p);
    end
    run_mul(16'h8000, 16'h0002, 0, 1'b0, p);
    checks++;
    if (p !== 16'h0000 || out_zr !== 1'b1) begin
      errors++;
      $display("FAIL wrap_8000 got %h zr%b expected 0000 zr1", p, out_zr);
    end
  endtask

  task automatic test_zero;
    logic [W-1:0] p;
    run_mul(16'h0005, 16'h0000, 0, 1'b0, p);
    checks++;
    if (p !== 16'h0000) begin
      errors++;
      $display("FAIL zero_b got %h expected 0000", p);
    end
  endtask

  task automatic test_hold_noise;
    logic [W-1:0] p;
    run_mul(16'h1234, 16'h0056, 5, 1'b1, p);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] p;
    in_a = 16'h7777;
    in_b = 16'h9999;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b101010) begin
      errors++;
      $display("FAIL reset_mid got rdy%b vld%b code%b expected rdy1 vld0 code101010",
               in_ready, out_valid, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    end
    run_mul(16'd3, 16'd4, 0, 1'b0, p);
    checks++;
    if (p !== 16'h000C) begin
      errors++;
      $display("FAIL after_reset got %h expected 000c", p);
    end
  endtask

  task automatic test_signed;
    logic [W-1:0] p;
    run_mul(16'hFFFD, 16'd7, 0, 1'b0, p);
    checks++;
    if (p !== 16'hFFEB || out_ng !== 1'b1) begin
      errors++;
      $display("FAIL signed got %h ng%b expected ffeb ng1", p, out_ng);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] p, a, b;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom) >> $urandom_range(0, 15);
      run_mul(a, b, $urandom_range(0, 2), 1'($urandom), p);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_hold_noise();
    test_reset_mid();
    test_signed();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
